simple_st0_calc: RTL
====================

# simple_st0_calc

Compute stage directly downstream of the stage-0 memory wrapper (tap, bias and data memories). On a `start` pulse it reads the 6-element input vector from data memory, then for each of the 4 output neurons reads one 192-bit tap row and one bias word. It computes `y[n] = bias[n] + sum_k tap[n][k]*data[k]` with a sequential multiply-accumulate and streams the 4 saturated 32-bit results out on a valid/ready port to the next stage.

## Interface
Parameters:
- `DATA_W`, 32, width of data, bias, tap element and result
- `N_TAPS`, 6, data-memory depth and taps per row
- `N_OUT`, 4, tap/bias memory depth and number of outputs

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle pulse: data memory is loaded, begin computation
- `data_rd_en`  out  1  data-memory read enable
- `data_rd_addr`  out  3  data-memory read address
- `data_int_rd_data`  in  32  data word, valid 1 cycle after `data_rd_en`
- `tap_rd_en`  out  1  tap-memory read enable
- `tap_rd_addr`  out  2  tap row address (= neuron index)
- `tap_int_rd_data`  in  192  tap row; tap k in bits [32k+31:32k]; valid 1 cycle after `tap_rd_en`
- `bias_rd_en`  out  1  bias-memory read enable, same cycle as `tap_rd_en`
- `bias_rd_addr`  out  2  bias address (= neuron index)
- `bias_int_rd_data`  in  32  bias word, valid 1 cycle after `bias_rd_en`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_data`  out  32  signed saturated result
- `out_index`  out  2  neuron index of `out_data`
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse on the cycle of the 4th output handshake

## Operation
- All values are signed two's complement integers.
- FSM states:
  - IDLE: `start` moves to LOAD. `start` is ignored in every other state.
  - LOAD: 6 cycles. `data_rd_en`=1, address 0..5. Each returned word is captured one cycle later into local register d[0..5]. Capture of d[5] happens in the first ROW cycle.
  - ROW: 1 cycle. `tap_rd_en`=`bias_rd_en`=1, address = n.
  - MAC: 6 cycles, k=0..5.
    - k=0: acc = sext(bias) + tap[n][0]*d[0].
    - k>0: acc += tap[n][k]*d[k].
    - The tap row and bias are registered in the k=0 cycle and held.
  - OUT: `out_valid`=1, `out_data`=sat32(acc), `out_index`=n.
    - On `out_valid&&out_ready`: if n<3, then n++ and go to ROW. If n=3, pulse `done` and go to IDLE.
- Arithmetic:
  - Each product is a full 64-bit signed value.
  - The accumulator is 66-bit signed, so no internal overflow is possible.
  - sat32 clamps to [0x80000000, 0x7FFFFFFF].
- Backpressure: with `out_ready` low, the block stays in OUT. `out_data` and `out_index` are held stable and no memory reads are issued.
- Memory contents are not re-read during a run. Upstream must not write data memory while `busy`=1.

## Timing
- Reset values:
  - `out_valid`, `done`, `busy`, all `*_rd_en` = 0.
  - `out_data`, `out_index`, all addresses = 0.
  - FSM = IDLE, n = 0.
- Reset mid-run: all outputs return to reset values on the next cycle. Partial results are discarded and no `done` is produced.
- Cycle numbering, with `start` sampled at cycle 0:
  - LOAD: cycles 1–6.
  - ROW: cycle 7.
  - MAC: cycles 8–13.
  - First `out_valid`: cycle 14.
- With `out_ready` tied high, outputs are 8 cycles apart (cycles 14, 22, 30, 38). `done` asserts at cycle 38, and `busy` drops at cycle 39.
- A `start` in the same cycle as `done` is ignored. The earliest accepted restart is cycle 39.
- `out_valid` never drops without a handshake, except on reset.

## Structure
- Shared package/types file holds:
  - constants `N_TAPS`=6, `N_OUT`=4, `DATA_W`=32, `ACC_W`=66
  - FSM state enum (IDLE, LOAD, ROW, MAC, OUT)
  - the tap-row slice convention
- One sub-module, `simple_st0_calc_mac`:
  - registered 32x32 signed multiply, 66-bit accumulate with init/accumulate select, sat32 output
- The top level holds the FSM, counters, data register file and output register.

## Test plan
- **Basic run:** data = 1..6, tap row n all = n+1, bias[n] = 10n, `out_ready`=1.
  - Results, in order: (0, 21), (1, 52), (2, 83), (3, 114).
  - `done` at cycle 38.
- **Saturation:**
  - All data and taps 0x7FFFFFFF, bias 0 → every output 0x7FFFFFFF.
  - Taps 0x80000000, data 0x7FFFFFFF → every output 0x80000000.
- **Backpressure:** `out_ready` low for 5 cycles while index 1 is valid.
  - `out_data` = 52 and `out_index` = 1 stay stable.
  - No `*_rd_en` asserted.
  - Second-to-fourth outputs are delayed by exactly 5 cycles.
- **Ignored start:** extra `start` pulses at cycles 3, 20 and 38.
  - No effect; exactly 4 outputs and 1 `done`.
  - A `start` at cycle 39 begins a new identical run.
- **Reset mid-run:** `reset` at cycle 10 (during MAC).
  - Next cycle, all outputs are at reset values.
  - A subsequent `start` gives correct results with latency 14.
- **Read-sequence check:**
  - `data_rd_addr` = 0..5 on cycles 1–6.
  - `tap_rd_addr` = `bias_rd_addr` = n on each ROW cycle.
  - Exactly 6 data reads and 4 tap/bias reads per run.

Source files
------------

// File: rtl/simple_st0_calc_pkg.sv
// Shared constants, FSM state type and helpers for the stage-0 compute block.
package simple_st0_calc_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned N_TAPS  = 6;
  localparam int unsigned N_OUT   = 4;
  localparam int unsigned ACC_W   = 66;
  localparam int unsigned ROW_W   = DATA_W * N_TAPS;
  localparam int unsigned DADDR_W = 3;
  localparam int unsigned NIDX_W  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRow,
    StMac,
    StOut
  } state_e;

  // Tap k of a row lives in bits [32k+31:32k].
  function automatic logic [DATA_W-1:0] tap_elem(input logic [ROW_W-1:0] row,
                                                  input logic [DADDR_W-1:0] k);
    return row[k*DATA_W +: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] sat32(input logic [ACC_W-1:0] v);
    logic [ACC_W-DATA_W:0] hi;
    hi = v[ACC_W-1:DATA_W-1];
    if (hi == '0 || hi == '1) begin
      return v[DATA_W-1:0];
    end else if (v[ACC_W-1]) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/simple_st0_calc_if.sv
// Result stream from the compute block to the next stage (valid/ready).
interface simple_st0_calc_if;
  import simple_st0_calc_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [NIDX_W-1:0] out_index;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    output out_ready
  );

endinterface

// File: rtl/simple_st0_calc_mac.sv
// Signed 32x32 multiply with 66-bit accumulator; result is the saturated accumulator.
module simple_st0_calc_mac
  import simple_st0_calc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              init,
  input  logic [DATA_W-1:0] bias,
  input  logic [DATA_W-1:0] tap,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] result
);

  logic [2*DATA_W-1:0] tap_x;
  logic [2*DATA_W-1:0] data_x;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    base;
  logic [ACC_W-1:0]    acc_d;
  logic [ACC_W-1:0]    acc_q;

  always_comb begin
    tap_x  = {{DATA_W{tap[DATA_W-1]}}, tap};
    data_x = {{DATA_W{data[DATA_W-1]}}, data};
    prod   = $signed(tap_x) * $signed(data_x);
    // init starts a fresh neuron from the sign-extended bias
    base   = init ? {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} : acc_q;
    acc_d  = base + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
    end
  end

  assign result = sat32(acc_q);

endmodule

// File: rtl/simple_st0_calc.sv
// Stage-0 compute: loads the input vector, then per neuron reads taps/bias,
// runs a 6-step MAC and streams the saturated result downstream.
module simple_st0_calc
  import simple_st0_calc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               data_rd_en,
  output logic [DADDR_W-1:0] data_rd_addr,
  input  logic [DATA_W-1:0]  data_int_rd_data,
  output logic               tap_rd_en,
  output logic [NIDX_W-1:0]  tap_rd_addr,
  input  logic [ROW_W-1:0]   tap_int_rd_data,
  output logic               bias_rd_en,
  output logic [NIDX_W-1:0]  bias_rd_addr,
  input  logic [DATA_W-1:0]  bias_int_rd_data,
  simple_st0_calc_if.master  result,
  output logic               busy,
  output logic               done
);

  localparam logic [DADDR_W-1:0] LastK = DADDR_W'(N_TAPS - 1);
  localparam logic [NIDX_W-1:0]  LastN = NIDX_W'(N_OUT - 1);

  state_e             state_q;
  logic [NIDX_W-1:0]  n_q;
  logic [DADDR_W-1:0] k_q;
  logic [DADDR_W-1:0] load_addr_q;
  logic               data_rd_en_q;
  logic               tap_rd_en_q;
  logic               out_valid_q;
  logic               busy_q;

  logic               cap_en_q;
  logic [DADDR_W-1:0] cap_addr_q;
  logic [DATA_W-1:0]  d_q [N_TAPS];
  logic [ROW_W-1:0]   tap_row_q;

  logic               mac_en;
  logic               mac_init;
  logic [DATA_W-1:0]  mac_tap;
  logic [DATA_W-1:0]  mac_data;
  logic [DATA_W-1:0]  mac_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      n_q          <= '0;
      k_q          <= '0;
      load_addr_q  <= '0;
      data_rd_en_q <= 1'b0;
      tap_rd_en_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q      <= StLoad;
            data_rd_en_q <= 1'b1;
            load_addr_q  <= '0;
            n_q          <= '0;
            busy_q       <= 1'b1;
          end
        end
        StLoad: begin
          if (load_addr_q == LastK) begin
            data_rd_en_q <= 1'b0;
            tap_rd_en_q  <= 1'b1;
            state_q      <= StRow;
          end else begin
            load_addr_q <= load_addr_q + 3'd1;
          end
        end
        StRow: begin
          tap_rd_en_q <= 1'b0;
          k_q         <= '0;
          state_q     <= StMac;
        end
        StMac: begin
          if (k_q == LastK) begin
            out_valid_q <= 1'b1;
            state_q     <= StOut;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        StOut: begin
          if (result.out_ready) begin
            out_valid_q <= 1'b0;
            if (n_q == LastN) begin
              n_q     <= '0;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              n_q         <= n_q + 2'd1;
              tap_rd_en_q <= 1'b1;
              state_q     <= StRow;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read data lands one cycle after the request, so capture trails the address by one.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_en_q   <= 1'b0;
      cap_addr_q <= '0;
      tap_row_q  <= '0;
      for (int i = 0; i < N_TAPS; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      cap_en_q   <= data_rd_en_q;
      cap_addr_q <= load_addr_q;
      if (cap_en_q) begin
        d_q[cap_addr_q] <= data_int_rd_data;
      end
      if (state_q == StMac && k_q == '0) begin
        tap_row_q <= tap_int_rd_data;
      end
    end
  end

  // k=0 consumes the row straight from memory; later steps use the held copy.
  always_comb begin
    mac_en   = (state_q == StMac);
    mac_init = (k_q == '0);
    mac_tap  = mac_init ? tap_elem(tap_int_rd_data, '0) : tap_elem(tap_row_q, k_q);
    mac_data = d_q[k_q];
  end

  simple_st0_calc_mac u_mac (
    .clk    (clk),
    .reset  (reset),
    .en     (mac_en),
    .init   (mac_init),
    .bias   (bias_int_rd_data),
    .tap    (mac_tap),
    .data   (mac_data),
    .result (mac_result)
  );

  assign data_rd_en   = data_rd_en_q;
  assign data_rd_addr = load_addr_q;
  assign tap_rd_en    = tap_rd_en_q;
  assign tap_rd_addr  = n_q;
  assign bias_rd_en   = tap_rd_en_q;
  assign bias_rd_addr = n_q;

  assign result.out_valid = out_valid_q;
  assign result.out_data  = mac_result;
  assign result.out_index = n_q;

  assign busy = busy_q;
  assign done = out_valid_q && result.out_ready && (n_q == LastN);

endmodule
